fifo_rd_unpacker: RTL
=====================

Name: fifo_rd_unpacker

Overview:
- Single-clock reader that sits on the read (pvalid/pdata/pready) side of the CDC FIFO, in the read clock domain.
- Accepts one wide word per ready/valid handshake and emits it as ratio_p narrow chunks on a downstream ready/valid interface.
- Flags the final chunk of each word with last_o.
- Sustains full throughput: a new wide word is accepted in the same cycle its predecessor's last chunk is consumed.

Parameters:
- width_p, 32: width of the wide input word.
- ratio_p, 4: number of output chunks per input word. Must be ≥2 and divide width_p evenly.
- lsb_first_p, 1: 1 emits chunk 0 (bits [chunk_w-1:0]) first; 0 emits the most significant chunk first.
- Derived: chunk_w = width_p/ratio_p; cnt_w = $clog2(ratio_p).

Ports:
- clk_i  input  1  clock.
- reset_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  wide word available (driven from the FIFO's pvalid_o).
- data_i  input  width_p  wide word (from the FIFO's pdata_o).
- ready_o  output  1  block accepts data_i this cycle (drives the FIFO's pready_i).
- valid_o  output  1  chunk on data_o is valid.
- data_o  output  chunk_w  current narrow chunk.
- last_o  output  1  current chunk is the final chunk of its word.
- ready_i  input  1  downstream accepts the chunk.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk_i, reset_ni).
- Reset: while reset_ni=0, and immediately on its falling edge (no clock required):
  - valid_o=0, last_o=0, data_o=0.
  - ready_o=1 in the first cycle after reset deassertion.
  - Holding register cleared; chunk counter = 0; state = EMPTY.
- State: EMPTY or FULL. FULL means the holding register contains a word with unsent chunks.
- Input handshake: accept when valid_i & ready_o.
  - EMPTY: ready_o=1 unconditionally.
  - FULL: ready_o = ready_i & (cnt == ratio_p-1).
  - This combinational path from ready_i to ready_o is intentional and documented.
- Output handshake: a chunk is consumed when valid_o & ready_i. valid_o = (state == FULL).
- data_o selection:
  - lsb_first_p=1: data_o = hold[cnt*chunk_w +: chunk_w].
  - lsb_first_p=0: data_o = hold[(ratio_p-1-cnt)*chunk_w +: chunk_w].
  - data_o is 0 when EMPTY.
- last_o = valid_o & (cnt == ratio_p-1).
- Transitions, evaluated each clock edge:
  - EMPTY, input accepted → FULL; hold ← data_i; cnt ← 0. Latency: the first chunk is visible the cycle after acceptance.
  - FULL, chunk consumed, cnt < ratio_p-1 → cnt ← cnt+1.
  - FULL, last chunk consumed, no input accepted → EMPTY; cnt ← 0.
  - FULL, last chunk consumed and input accepted in the same cycle → stay FULL; hold ← data_i; cnt ← 0. No bubble.
  - FULL, ready_i=0 → hold all state. data_o and last_o stay stable. valid_o never retracts without a handshake.
- Counter: cnt_w bits. It never exceeds ratio_p-1, including for non-power-of-two ratio_p (e.g. 3); it resets to 0 explicitly rather than by wrap-around.
- Input side: the block never samples data_i unless the handshake fires; valid_i while FULL and not at the last chunk is ignored (not lost: the FIFO holds it).
- Reset mid-word: any partial word is discarded. After release, output resumes only with a newly accepted word.
- Throughput: with ready_i held at 1 and valid_i held at 1, valid_o=1 every cycle and one input word is taken every ratio_p cycles.

Test Plan:
- Reset, then word 0xDDCCBBAA with ratio_p=4, lsb_first_p=1, ready_i=1:
  - Expect data_o = 0xAA, 0xBB, 0xCC, 0xDD on 4 consecutive cycles starting 1 cycle after acceptance.
  - last_o=1 only with 0xDD; then valid_o=0.
- Same word with lsb_first_p=0 → 0xDD, 0xCC, 0xBB, 0xAA; last_o with 0xAA.
- Back-to-back words 0x44332211 and 0x88776655, valid_i=1, ready_i=1:
  - valid_o=1 for 8 consecutive cycles; ready_o pulses exactly in the cycles carrying 0x44 and 0x88.
  - Output sequence 11,22,33,44,55,66,77,88.
- Backpressure: ready_i=0 for 3 cycles while 0xBB is presented → data_o=0xBB, valid_o=1, ready_o=0 held stable throughout; sequence resumes with 0xCC after ready_i returns to 1.
- Reset mid-word: assert reset_ni=0 asynchronously after 0xBB is consumed:
  - valid_o=0 before the next clock edge.
  - After release, feed 0x0F0E0D0C → output 0x0C, 0x0D, 0x0E, 0x0F; no stale 0xCC/0xDD appears.
- ratio_p=3, width_p=24, word 0x332211:
  - Output 0x11, 0x22, 0x33; last_o on 0x33.
  - Counter never reaches 3; random ready_i/valid_i over 1000 words matches the scoreboard.

Source files
------------

// File: rtl/fifo_rd_unpacker.sv
// Read-side unpacker for the CDC FIFO: takes one wide word per handshake and
// replays it as ratio_p narrow chunks, flagging the final chunk with last_o.
module fifo_rd_unpacker #(
  parameter int unsigned width_p     = 32,
  parameter int unsigned ratio_p     = 4,
  parameter bit          lsb_first_p = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         valid_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [width_p/ratio_p-1:0]   data_o,
  output logic                         last_o,
  input  logic                         ready_i
);

  localparam int unsigned chunk_w = width_p / ratio_p;
  localparam int unsigned cnt_w   = (ratio_p > 1) ? $clog2(ratio_p) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(ratio_p - 1);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e              state_q, state_d;
  logic [width_p-1:0]  hold_q, hold_d;
  logic [cnt_w-1:0]    cnt_q, cnt_d;
  logic                at_last;
  logic                accept;

  // ready_o depends combinationally on ready_i so a new word can be taken in
  // the same cycle the last chunk of the previous one leaves.
  always_comb begin
    at_last = (cnt_q == cnt_last);
    valid_o = (state_q == StFull);
    last_o  = valid_o & at_last;
    ready_o = (state_q == StEmpty) | (ready_i & at_last);
    accept  = valid_i & ready_o;
    data_o  = '0;
    if (valid_o) begin
      for (int unsigned i = 0; i < ratio_p; i++) begin
        if (cnt_q == cnt_w'(i)) begin
          data_o = lsb_first_p ? hold_q[i*chunk_w +: chunk_w]
                               : hold_q[(ratio_p-1-i)*chunk_w +: chunk_w];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
          hold_d  = data_i;
          cnt_d   = '0;
        end
      end
      StFull: begin
        if (ready_i) begin
          if (!at_last) begin
            cnt_d = cnt_q + cnt_w'(1);
          end else if (accept) begin
            hold_d = data_i;
            cnt_d  = '0;
          end else begin
            state_d = StEmpty;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StEmpty;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StEmpty;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
